// File: rtl/vx_fetch_sched_pkg.sv
// Shared constants and helpers for the per-warp fetch scheduler.
// PC width, reset PC default and the fetch stride live here so every file agrees.
package vx_fetch_sched_pkg;

    localparam int              PC_W         = 32;
    localparam logic [PC_W-1:0] PC_RESET_DEF = 32'h8000_0000;
    localparam logic [PC_W-1:0] PC_STEP      = 32'd4;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request after rr_last_i,
// wrapping modulo NUM_REQS (NUM_REQS must be a power of two).
module vx_rr_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int IDX_W    = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] req_i,
    input  logic [IDX_W-1:0]    rr_last_i,
    output logic [NUM_REQS-1:0] grant_oh_o,
    output logic [IDX_W-1:0]    grant_idx_o,
    output logic                grant_valid_o
);

    logic [IDX_W-1:0] cand;

    // Scan farthest-first so the nearest requester after rr_last_i overwrites the rest.
    always_comb begin
        cand          = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int i = NUM_REQS; i >= 1; i--) begin
            cand = rr_last_i + IDX_W'(i);
            if (req_i[cand]) begin
                grant_idx_o   = cand;
                grant_valid_o = 1'b1;
            end
        end
        grant_oh_o = grant_valid_o ? (NUM_REQS'(1) << grant_idx_o) : '0;
    end

endmodule

// File: rtl/vx_fetch_sched.sv
// Per-warp fetch scheduler: keeps PC/mask/status per warp and issues at most one
// outstanding fetch per warp, picking among eligible warps round-robin.
module vx_fetch_sched
    import vx_fetch_sched_pkg::*;
#(
    parameter int              NUM_WARPS   = 4,
    parameter int              NUM_THREADS = 4,
    parameter int              NW_BITS     = $clog2(NUM_WARPS),
    parameter logic [PC_W-1:0] PC_RESET    = PC_RESET_DEF
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   warp_ctl_valid,
    input  logic [NW_BITS-1:0]     warp_ctl_wid,
    input  logic [NUM_THREADS-1:0] warp_ctl_tmask,
    input  logic                   warp_ctl_pc_valid,
    input  logic [PC_W-1:0]        warp_ctl_pc,

    input  logic                   wstall_valid,
    input  logic [NW_BITS-1:0]     wstall_wid,

    input  logic                   branch_valid,
    input  logic [NW_BITS-1:0]     branch_wid,
    input  logic                   branch_taken,
    input  logic [PC_W-1:0]        branch_dest,

    output logic                   ifetch_req_valid,
    input  logic                   ifetch_req_ready,
    output logic [NW_BITS-1:0]     ifetch_req_wid,
    output logic [PC_W-1:0]        ifetch_req_PC,
    output logic [NUM_THREADS-1:0] ifetch_req_tmask,

    input  logic                   ifetch_rsp_fire,
    input  logic [NW_BITS-1:0]     ifetch_rsp_wid,

    output logic                   busy
);

    logic [NUM_WARPS-1:0]   active_q,   active_d;
    logic [NUM_WARPS-1:0]   stalled_q,  stalled_d;
    logic [NUM_WARPS-1:0]   inflight_q, inflight_d;
    logic [PC_W-1:0]        pc_q    [NUM_WARPS];
    logic [PC_W-1:0]        pc_d    [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
    logic [NW_BITS-1:0]     rr_last_q, rr_last_d;

    logic                   req_valid_q, req_valid_d;
    logic [NW_BITS-1:0]     req_wid_q,   req_wid_d;
    logic [PC_W-1:0]        req_pc_q,    req_pc_d;
    logic [NUM_THREADS-1:0] req_tmask_q, req_tmask_d;

    logic [NUM_WARPS-1:0]   eligible;
    logic [NUM_WARPS-1:0]   grant_oh;
    logic [NW_BITS-1:0]     grant_idx;
    logic                   grant_valid;
    logic                   slot_free;

    assign eligible  = active_q & ~stalled_q & ~inflight_q;
    assign slot_free = ~req_valid_q | ifetch_req_ready;

    vx_rr_arbiter #(
        .NUM_REQS (NUM_WARPS),
        .IDX_W    (NW_BITS)
    ) u_arb (
        .req_i         (eligible),
        .rr_last_i     (rr_last_q),
        .grant_oh_o    (grant_oh),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // Later statements win: selection < response < wstall < branch < warp control.
    always_comb begin
        active_d    = active_q;
        stalled_d   = stalled_q;
        inflight_d  = inflight_q;
        pc_d        = pc_q;
        tmask_d     = tmask_q;
        rr_last_d   = rr_last_q;
        req_valid_d = req_valid_q;
        req_wid_d   = req_wid_q;
        req_pc_d    = req_pc_q;
        req_tmask_d = req_tmask_q;

        if (slot_free) begin
            req_valid_d = grant_valid;
            if (grant_valid) begin
                req_wid_d          = grant_idx;
                req_pc_d           = pc_q[grant_idx];
                req_tmask_d        = tmask_q[grant_idx];
                inflight_d         = inflight_d | grant_oh;
                pc_d[grant_idx]    = pc_q[grant_idx] + PC_STEP;
                rr_last_d          = grant_idx;
            end
        end

        if (ifetch_rsp_fire) begin
            inflight_d[ifetch_rsp_wid] = 1'b0;
        end

        if (wstall_valid) begin
            stalled_d[wstall_wid] = 1'b1;
        end

        if (branch_valid) begin
            stalled_d[branch_wid] = 1'b0;
            if (branch_taken) begin
                pc_d[branch_wid] = word_align(branch_dest);
            end
        end

        // Deactivation leaves inflight alone; the outstanding fetch still drains.
        if (warp_ctl_valid) begin
            if (warp_ctl_tmask != '0) begin
                active_d[warp_ctl_wid] = 1'b1;
                tmask_d[warp_ctl_wid]  = warp_ctl_tmask;
                if (warp_ctl_pc_valid) begin
                    pc_d[warp_ctl_wid] = word_align(warp_ctl_pc);
                end
            end else begin
                active_d[warp_ctl_wid]  = 1'b0;
                stalled_d[warp_ctl_wid] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q    <= NUM_WARPS'(1);
            stalled_q   <= '0;
            inflight_q  <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]    <= (w == 0) ? PC_RESET : '0;
                tmask_q[w] <= (w == 0) ? NUM_THREADS'(1) : '0;
            end
            rr_last_q   <= NW_BITS'(NUM_WARPS - 1);
            req_valid_q <= 1'b0;
            req_wid_q   <= '0;
            req_pc_q    <= '0;
            req_tmask_q <= '0;
        end else begin
            active_q    <= active_d;
            stalled_q   <= stalled_d;
            inflight_q  <= inflight_d;
            pc_q        <= pc_d;
            tmask_q     <= tmask_d;
            rr_last_q   <= rr_last_d;
            req_valid_q <= req_valid_d;
            req_wid_q   <= req_wid_d;
            req_pc_q    <= req_pc_d;
            req_tmask_q <= req_tmask_d;
        end
    end

    assign ifetch_req_valid = req_valid_q;
    assign ifetch_req_wid   = req_wid_q;
    assign ifetch_req_PC    = req_pc_q;
    assign ifetch_req_tmask = req_tmask_q;
    assign busy             = (|active_q) | (|inflight_q) | req_valid_q;

    // A response must belong to a fetch this block issued.
    rsp_has_inflight: assert property (@(posedge clk) disable iff (!reset)
        ifetch_rsp_fire |-> inflight_q[ifetch_rsp_wid]);

endmodule

// File: tb/tb_vx_fetch_sched.sv
// Directed + randomized bench for vx_fetch_sched against a per-warp behavioural model.
module tb_vx_fetch_sched;

    localparam int NW  = 4;
    localparam int NT  = 4;
    localparam int NWB = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            warp_ctl_valid, warp_ctl_pc_valid;
    logic [NWB-1:0]  warp_ctl_wid;
    logic [NT-1:0]   warp_ctl_tmask;
    logic [31:0]     warp_ctl_pc;
    logic            wstall_valid;
    logic [NWB-1:0]  wstall_wid;
    logic            branch_valid, branch_taken;
    logic [NWB-1:0]  branch_wid;
    logic [31:0]     branch_dest;
    logic            ifetch_req_valid, ifetch_req_ready;
    logic [NWB-1:0]  ifetch_req_wid;
    logic [31:0]     ifetch_req_PC;
    logic [NT-1:0]   ifetch_req_tmask;
    logic            ifetch_rsp_fire;
    logic [NWB-1:0]  ifetch_rsp_wid;
    logic            busy;

    vx_fetch_sched #(.NUM_WARPS(NW), .NUM_THREADS(NT)) dut (
        .clk               (clk),
        .reset             (reset),
        .warp_ctl_valid    (warp_ctl_valid),
        .warp_ctl_wid      (warp_ctl_wid),
        .warp_ctl_tmask    (warp_ctl_tmask),
        .warp_ctl_pc_valid (warp_ctl_pc_valid),
        .warp_ctl_pc       (warp_ctl_pc),
        .wstall_valid      (wstall_valid),
        .wstall_wid        (wstall_wid),
        .branch_valid      (branch_valid),
        .branch_wid        (branch_wid),
        .branch_taken      (branch_taken),
        .branch_dest       (branch_dest),
        .ifetch_req_valid  (ifetch_req_valid),
        .ifetch_req_ready  (ifetch_req_ready),
        .ifetch_req_wid    (ifetch_req_wid),
        .ifetch_req_PC     (ifetch_req_PC),
        .ifetch_req_tmask  (ifetch_req_tmask),
        .ifetch_rsp_fire   (ifetch_rsp_fire),
        .ifetch_rsp_wid    (ifetch_rsp_wid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int rsp_pct = 0;
    int fired_q[$];

    bit          m_active[NW], m_stalled[NW], m_inflight[NW];
    logic [31:0] m_pc[NW];
    logic [3:0]  m_tmask[NW];
    int          m_rr;
    bit          m_valid;
    int          m_wid;
    logic [31:0] m_pco;
    logic [3:0]  m_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_active[w] = (w == 0); m_stalled[w] = 0; m_inflight[w] = 0;
            m_pc[w] = (w == 0) ? 32'h8000_0000 : 32'h0;
            m_tmask[w] = (w == 0) ? 4'h1 : 4'h0;
        end
        m_rr = NW - 1; m_valid = 0; m_wid = 0; m_pco = 0; m_tmo = 0;
        fired_q.delete();
    endtask

    // One clock of the scheduler rules, evaluated on the state before the edge.
    task automatic model_step();
        bit elig[NW];
        bit free;
        int g;
        for (int w = 0; w < NW; w++) elig[w] = m_active[w] && !m_stalled[w] && !m_inflight[w];
        free = !m_valid || ifetch_req_ready;
        if (m_valid && ifetch_req_ready) fired_q.push_back(m_wid);
        g = -1;
        if (free) for (int k = 1; k <= NW; k++) if (g < 0 && elig[(m_rr + k) % NW]) g = (m_rr + k) % NW;
        if (free) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_wid = g; m_pco = m_pc[g]; m_tmo = m_tmask[g];
                m_inflight[g] = 1; m_pc[g] = m_pc[g] + 32'd4; m_rr = g;
            end
        end
        if (ifetch_rsp_fire) m_inflight[ifetch_rsp_wid] = 0;
        if (wstall_valid) m_stalled[wstall_wid] = 1;
        if (branch_valid) begin
            m_stalled[branch_wid] = 0;
            if (branch_taken) m_pc[branch_wid] = branch_dest & ~32'h3;
        end
        if (warp_ctl_valid) begin
            if (warp_ctl_tmask != 0) begin
                m_active[warp_ctl_wid] = 1; m_tmask[warp_ctl_wid] = warp_ctl_tmask;
                if (warp_ctl_pc_valid) m_pc[warp_ctl_wid] = warp_ctl_pc & ~32'h3;
            end else begin
                m_active[warp_ctl_wid] = 0; m_stalled[warp_ctl_wid] = 0;
            end
        end
    endtask

    task automatic check_model();
        bit mbusy;
        mbusy = m_valid;
        for (int w = 0; w < NW; w++) mbusy = mbusy | m_active[w] | m_inflight[w];
        chk("req_valid", 32'(ifetch_req_valid), 32'(m_valid));
        if (m_valid) begin
            chk("req_wid", 32'(ifetch_req_wid), 32'(m_wid));
            chk("req_pc", ifetch_req_PC, m_pco);
            chk("req_tmask", 32'(ifetch_req_tmask), 32'(m_tmo));
        end
        chk("busy", 32'(busy), 32'(mbusy));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_step();
        #1;
        check_model();
        warp_ctl_valid = 0; wstall_valid = 0; branch_valid = 0; ifetch_rsp_fire = 0;
        if (rsp_pct != 0 && fired_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
            int i;
            i = $urandom_range(fired_q.size() - 1);
            ifetch_rsp_wid = NWB'(fired_q[i]);
            fired_q.delete(i);
            ifetch_rsp_fire = 1;
        end
    endtask

    task automatic give_rsp(input int w);
        for (int i = 0; i < fired_q.size(); i++) begin
            if (fired_q[i] == w) begin
                fired_q.delete(i);
                break;
            end
        end
        ifetch_rsp_fire = 1; ifetch_rsp_wid = NWB'(w);
    endtask

    task automatic set_ctl(input int w, input logic [3:0] tm, input bit pcv, input logic [31:0] pc);
        warp_ctl_valid = 1; warp_ctl_wid = NWB'(w); warp_ctl_tmask = tm;
        warp_ctl_pc_valid = pcv; warp_ctl_pc = pc;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0;
        warp_ctl_valid = 0; warp_ctl_wid = 0; warp_ctl_tmask = 0; warp_ctl_pc_valid = 0; warp_ctl_pc = 0;
        wstall_valid = 0; wstall_wid = 0;
        branch_valid = 0; branch_wid = 0; branch_taken = 0; branch_dest = 0;
        ifetch_req_ready = 1; ifetch_rsp_fire = 0; ifetch_rsp_wid = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ifetch_req_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_wid", 32'(ifetch_req_wid), 32'd0);
        chk("rst_pc", ifetch_req_PC, 32'h0);
        chk("rst_tmask", 32'(ifetch_req_tmask), 32'h0);
        reset = 1;

        // First fetch of warp 0, then silence until its response.
        step();
        chk("first_pc", ifetch_req_PC, 32'h8000_0000);
        chk("first_tmask", 32'(ifetch_req_tmask), 32'h1);
        repeat (3) step();
        chk("one_outstanding", 32'(ifetch_req_valid), 32'd0);
        give_rsp(0);
        step();
        step();
        chk("second_valid", 32'(ifetch_req_valid), 32'd1);
        chk("second_pc", ifetch_req_PC, 32'h8000_0004);

        // Bring up warps 1..3 with immediate responses.
        rsp_pct = 100;
        set_ctl(1, 4'hF, 1, 32'h1000); step();
        set_ctl(2, 4'hF, 1, 32'h2000); step();
        set_ctl(3, 4'hF, 1, 32'h3000); step();
        repeat (16) step();

        // Backpressure: outputs must hold while not ready.
        ifetch_req_ready = 0;
        repeat (5) step();
        ifetch_req_ready = 1;
        repeat (4) step();

        // Stall warp 1, then redirect it with a misaligned target.
        wstall_valid = 1; wstall_wid = 1; step();
        repeat (8) step();
        branch_valid = 1; branch_wid = 1; branch_taken = 1; branch_dest = 32'h0001_0042; step();
        repeat (8) step();

        // Deactivate warp 3, then everyone, and let fetches drain.
        set_ctl(3, 4'h0, 0, 32'h0); step();
        repeat (10) step();
        for (int w = 0; w < 3; w++) begin set_ctl(w, 4'h0, 0, 32'h0); step(); end
        repeat (20) step();
        chk("drained_busy", 32'(busy), 32'd0);
        chk("drained_valid", 32'(ifetch_req_valid), 32'd0);

        // Reset while a request is held.
        rsp_pct = 0;
        @(negedge clk); reset = 0; model_reset();
        @(negedge clk); reset = 1; ifetch_req_ready = 0;
        step();
        step();
        chk("held_valid", 32'(ifetch_req_valid), 32'd1);
        @(negedge clk); reset = 0; model_reset();
        #1;
        chk("async_valid", 32'(ifetch_req_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd1);
        @(negedge clk); reset = 1; ifetch_req_ready = 1;
        step();
        chk("rerst_wid", 32'(ifetch_req_wid), 32'd0);
        chk("rerst_pc", ifetch_req_PC, 32'h8000_0000);
        chk("rerst_tmask", 32'(ifetch_req_tmask), 32'h1);

        // Randomized traffic.
        rsp_pct = 60;
        for (int c = 0; c < 3000; c++) begin
            ifetch_req_ready = ($urandom_range(3) != 0);
            if ($urandom_range(99) < 15)
                set_ctl($urandom_range(NW - 1), ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom),
                        1'($urandom), $urandom);
            if ($urandom_range(99) < 10) begin wstall_valid = 1; wstall_wid = NWB'($urandom); end
            if ($urandom_range(99) < 15) begin
                branch_valid = 1; branch_wid = NWB'($urandom);
                branch_taken = 1'($urandom); branch_dest = $urandom;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
